// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
// Core-side PS/2 keyboard receiver. Deserialises 11-bit PS/2 frames
// (start, 8 data LSB first, odd parity, stop) into bytes, decodes set-2
// E0 (extended) and F0 (break) prefixes into key events, and queues the
// events in a small FIFO read with a pop handshake.
//
// Ports:
//   clk_sys      in   system clock, all logic on its rising edge
//   reset        in   synchronous active-high reset
//   ps2_clk      in   PS/2 clock (asynchronous, idles high)
//   ps2_data     in   PS/2 data (asynchronous)
//   rx_byte      out  last correctly received byte
//   rx_strobe    out  one-cycle pulse when rx_byte updates
//   rx_err       out  one-cycle pulse on start/parity/stop/timeout error
//   key_valid    out  event FIFO not empty
//   key_code     out  scancode at FIFO head
//   key_pressed  out  head entry is a make (1) or break (0)
//   key_extended out  head entry was E0-prefixed
//   key_rd       in   pop the head entry (ignored when empty)
//   overflow     out  sticky: an event was dropped on a full FIFO
module ps2_kbd_rx #(
  parameter int TIMEOUT   = 5000,
  parameter int FIFO_BITS = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  input  logic       key_rd,
  output logic       overflow
);

  localparam int                 DEPTH    = 1 << FIFO_BITS;
  localparam int                 TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FIFO_BITS:0] FULL_CNT = (FIFO_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Frame is good when the stop bit is 1 and data+parity has an odd count of ones.
  function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic s);
    return s & (^{d, p});
  endfunction

  logic clk_meta_q, clk_sync_q, clk_prev_q, data_meta_q, data_sync_q;
  logic fall_s;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_strobe_q, rx_strobe_d;
  logic          rx_err_q, rx_err_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          push_q, push_d;
  logic [9:0]    push_ev_q, push_ev_d;

  logic [9:0]           mem_q [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 pop_s, full_s, wr_s;

  // Two-flop synchronisers; clock/data reset high (idle) so reset creates no fall event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall_s = clk_prev_q & ~clk_sync_q;

  // Receiver FSM, timeout counter and prefix decoder next-state logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    rx_byte_d   = rx_byte_q;
    rx_strobe_d = 1'b0;
    rx_err_d    = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;
    push_d      = 1'b0;
    push_ev_d   = push_ev_q;

    if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (fall_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if ((state_q != ST_IDLE) && !fall_s && (tmo_q == TMO_LAST)) begin
      // Link went quiet mid-frame: abandon it and forget any pending prefix.
      state_d  = ST_IDLE;
      rx_err_d = 1'b1;
      ext_d    = 1'b0;
      brk_d    = 1'b0;
      tmo_d    = '0;
    end else if (fall_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            rx_err_d  = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          parity_d = data_sync_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (frame_ok(shift_q, parity_q, data_sync_q)) begin
            rx_byte_d   = shift_q;
            rx_strobe_d = 1'b1;
            case (shift_q)
              8'hE0: ext_d = 1'b1;
              8'hF0: brk_d = 1'b1;
              8'hE1: ext_d = ext_q;
              8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                ext_d = 1'b0;
                brk_d = 1'b0;
              end
              default: begin
                push_d    = 1'b1;
                push_ev_d = {shift_q, ~brk_q, ext_q};
                ext_d     = 1'b0;
                brk_d     = 1'b0;
              end
            endcase
          end else begin
            rx_err_d = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Receiver and decoder state registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      rx_byte_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
      rx_err_q    <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      push_ev_q   <= 10'h000;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      rx_byte_q   <= rx_byte_d;
      rx_strobe_q <= rx_strobe_d;
      rx_err_q    <= rx_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      push_q      <= push_d;
      push_ev_q   <= push_ev_d;
    end
  end

  // FIFO control: a pop frees a slot in the same cycle, so push+pop on full is accepted.
  always_comb begin
    pop_s  = key_rd && (count_q != '0);
    full_s = (count_q == FULL_CNT);
    wr_s   = push_q && (!full_s || pop_s);
    ovf_d  = ovf_q | (push_q & full_s & ~pop_s);
    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + FIFO_BITS'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + FIFO_BITS'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + (FIFO_BITS + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_BITS + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'h000;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_q[wr_ptr_q] <= push_ev_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_strobe = rx_strobe_q;
  assign rx_err    = rx_err_q;
  assign key_valid = (count_q != '0);
  assign overflow  = ovf_q;
  assign {key_code, key_pressed, key_extended} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;

  localparam int TMO        = 5000;
  localparam int DEPTH      = 4;
  localparam int K_GOOD     = 0;
  localparam int K_BADFRAME = 1;
  localparam int K_TIMEOUT  = 2;
  localparam int K_BADSTART = 3;

  logic       clk_sys  = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_rd   = 1'b0;
  logic [7:0] rx_byte, key_code;
  logic       rx_strobe, rx_err, key_valid, key_pressed, key_extended, overflow;

  ps2_kbd_rx #(.TIMEOUT(TMO), .FIFO_BITS(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .rx_err(rx_err),
    .key_valid(key_valid), .key_code(key_code), .key_pressed(key_pressed),
    .key_extended(key_extended), .key_rd(key_rd), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Expected receiver outcome of one sent frame: a window of cycles and what must appear.
  typedef struct {
    int         lo;
    int         hi;
    int         kind;
    logic [7:0] b;
  } exp_t;

  exp_t       expq[$];
  logic [9:0] mq[$];          // model FIFO: {code, pressed, extended}
  logic [7:0] m_byte = 8'h00;
  bit         m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0, pend = 1'b0;
  logic [9:0] pend_ev = 10'h000;

  int cyc = 0;
  bit rst_seen = 1'b1, rd_seen = 1'b0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  // Scancode set-2 prefix rules applied to a received byte or error.
  task automatic model_apply(input exp_t e);
    case (e.kind)
      K_GOOD: begin
        m_byte = e.b;
        case (e.b)
          8'hE0: m_ext = 1'b1;
          8'hF0: m_brk = 1'b1;
          8'hE1: ;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin m_ext = 1'b0; m_brk = 1'b0; end
          default: begin
            pend_ev = {e.b, ~m_brk, m_ext};
            pend    = 1'b1;
            m_ext   = 1'b0;
            m_brk   = 1'b0;
          end
        endcase
      end
      K_BADFRAME, K_TIMEOUT: begin m_ext = 1'b0; m_brk = 1'b0; end
      default: ;
    endcase
  endtask

  always @(posedge clk_sys) begin
    cyc      = cyc + 1;
    rst_seen = reset;
    rd_seen  = key_rd;
  end

  // Compare process: advance the model to the state after the last edge, then check.
  always @(negedge clk_sys) begin
    if (rst_seen) begin
      mq.delete(); expq.delete();
      m_byte = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; pend = 1'b0;
    end else begin
      if (rd_seen && mq.size() != 0) void'(mq.pop_front());
      if (pend) begin
        if (mq.size() < DEPTH) mq.push_back(pend_ev);
        else m_ovf = 1'b1;
        pend = 1'b0;
      end
      if (expq.size() != 0 && cyc >= expq[0].lo && cyc <= expq[0].hi) begin
        if (rx_strobe || rx_err) begin
          chk("rx_strobe", 32'(rx_strobe), 32'(expq[0].kind == K_GOOD));
          chk("rx_err", 32'(rx_err), 32'(expq[0].kind != K_GOOD));
          model_apply(expq[0]);
          void'(expq.pop_front());
        end else if (cyc == expq[0].hi) begin
          chk("rx_event_seen", 32'(rx_strobe | rx_err), 32'd1);
          model_apply(expq[0]);
          void'(expq.pop_front());
        end
      end else begin
        chk("rx_spurious", 32'({rx_strobe, rx_err}), 32'd0);
      end
    end
    chk("rx_byte", 32'(rx_byte), 32'(m_byte));
    chk("key_valid", 32'(key_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("key_head", 32'({key_code, key_pressed, key_extended}), 32'(mq[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Send bits[0..nbits-1] as PS/2 clock periods; data changes while the clock is high.
  task automatic send_raw(input logic [10:0] bits, input int nbits, input int half,
                          input int kind, input bit rd_push);
    exp_t e;
    int   k;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(half);
      ps2_clk = 1'b0;
      k = cyc;
      if (i == nbits - 1) begin
        e.kind = kind;
        e.b    = bits[8:1];
        if (kind == K_TIMEOUT) begin
          e.lo = k + 3 + TMO - 2;
          e.hi = k + 3 + TMO + 2;
        end else begin
          e.lo = k + 3;
          e.hi = k + 3;
        end
        expq.push_back(e);
        if (rd_push) begin
          tick(3); key_rd = 1'b1;   // sampled on the edge that lands the push
          tick(1); key_rd = 1'b0;
          tick(half - 4);
        end else begin
          tick(half);
        end
      end else begin
        tick(half);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int half, input bit bad_par,
                           input bit bad_stop, input bit rd_push);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    send_raw(bits, 11, half, (bad_par || bad_stop) ? K_BADFRAME : K_GOOD, rd_push);
  endtask

  task automatic pop();
    key_rd = 1'b1; tick(1);
    key_rd = 1'b0; tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(3);
    reset = 1'b0; tick(1);
  endtask

  logic [7:0] specials [6] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00};
  logic [7:0] seq5     [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

  initial begin
    tick(2);
    do_reset();
    chk("reset_rx_byte", 32'(rx_byte), 32'h00);
    chk("reset_key_valid", 32'(key_valid), 32'd0);
    chk("reset_key_code", 32'({key_code, key_pressed, key_extended}), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Single make code.
    send_byte(8'h1C, 50, 1'b0, 1'b0, 1'b0);
    chk("lit_rx_byte_1c", 32'(rx_byte), 32'h1C);
    chk("lit_valid_1c", 32'(key_valid), 32'd1);
    chk("lit_code_1c", 32'({key_code, key_pressed, key_extended}), 32'({8'h1C, 1'b1, 1'b0}));
    pop();
    chk("lit_empty_after_pop", 32'(key_valid), 32'd0);

    // Extended break, then flags must be clear for the next make.
    send_byte(8'hE0, 50, 1'b0, 1'b0, 1'b0);
    send_byte(8'hF0, 50, 1'b0, 1'b0, 1'b0);
    send_byte(8'h75, 50, 1'b0, 1'b0, 1'b0);
    chk("lit_code_e0f075", 32'({key_code, key_pressed, key_extended}), 32'({8'h75, 1'b0, 1'b1}));
    pop();
    chk("lit_one_event", 32'(key_valid), 32'd0);
    send_byte(8'h1C, 50, 1'b0, 1'b0, 1'b0);
    chk("lit_flags_cleared", 32'({key_code, key_pressed, key_extended}), 32'({8'h1C, 1'b1, 1'b0}));
    pop();

    // Parity error leaves rx_byte and FIFO alone.
    send_byte(8'h1C, 50, 1'b1, 1'b0, 1'b0);
    chk("lit_bad_par_valid", 32'(key_valid), 32'd0);
    send_byte(8'h32, 50, 1'b0, 1'b0, 1'b0);
    chk("lit_after_bad_par", 32'(key_code), 32'h32);
    pop();

    // Partial frame then silence.
    send_raw(11'b000_0101_0100, 5, 50, K_TIMEOUT, 1'b0);
    tick(TMO + 20);
    send_byte(8'h1B, 50, 1'b0, 1'b0, 1'b0);
    chk("lit_after_timeout", 32'(key_code), 32'h1B);
    pop();

    // Overflow with five unread makes.
    for (int i = 0; i < 5; i++) send_byte(seq5[i], 30, 1'b0, 1'b0, 1'b0);
    chk("lit_overflow_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("lit_overflow_read", 32'(key_code), 32'(seq5[i]));
      pop();
    end
    chk("lit_overflow_drained", 32'(key_valid), 32'd0);

    // Full FIFO with a pop landing on the same cycle as the push.
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(seq5[i], 30, 1'b0, 1'b0, 1'b0);
    send_byte(seq5[4], 30, 1'b0, 1'b0, 1'b1);
    chk("lit_full_pushpop_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 5; i++) begin
      chk("lit_full_pushpop_read", 32'(key_code), 32'(seq5[i]));
      pop();
    end
    chk("lit_full_pushpop_drained", 32'(key_valid), 32'd0);

    // Randomised traffic against the model.
    do_reset();
    for (int it = 0; it < 30; it++) begin
      int         r;
      int         half;
      logic [7:0] b;
      r    = int'($urandom_range(0, 99));
      half = int'($urandom_range(10, 30));
      if ($urandom_range(0, 2) == 0) b = specials[$urandom_range(0, 5)];
      else b = 8'($urandom_range(0, 255));
      if (r < 8)       send_raw(11'h001, 1, half, K_BADSTART, 1'b0);
      else if (r < 16) send_byte(b, half, 1'b1, 1'b0, 1'b0);
      else if (r < 22) send_byte(b, half, 1'b0, 1'b1, 1'b0);
      else             send_byte(b, half, 1'b0, 1'b0, 1'b0);
      tick(int'($urandom_range(1, 20)));
      if ($urandom_range(0, 2) == 0) pop();
    end
    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
